// File: rtl/pipeline_debug_ctrl.sv
// Purpose: command sequencer that loads instruction memory and gates the pipeline enable (UART byte commands L/C/S).
// Latency: command byte -> o_pipe_reset 1 cycle; 4th load byte -> o_imem_we 1 cycle; i_halt -> o_enable low 1 cycle.
// Backpressure: none; one byte per i_rx_valid strobe is always accepted. Optional macro CYCLE_COUNT_EN adds the cycle counter.
module pipeline_debug_ctrl #(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   parameter logic [7:0]  CMD_LOAD  = 8'h4C,
   parameter logic [7:0]  CMD_RUN   = 8'h43,
   parameter logic [7:0]  CMD_STEP  = 8'h53
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   input  logic              i_halt,
   output logic              o_enable,
   output logic              o_pipe_reset,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_data,
   output logic              o_loaded,
   output logic              o_load_err,
   output logic              o_done,
   output logic [31:0]       o_cycle_count
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      STEP,
      DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [23:0] word_lo;
   logic [31:0] full_word;

   // The 4th byte completes the word combinationally so it can be written one cycle later.
   assign full_word = {i_rx_data, word_lo};

   // Main sequencer: state, load assembly and all control outputs are registered here.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= IDLE;
         byte_cnt     <= 2'd0;
         word_lo      <= 24'd0;
         o_enable     <= 1'b0;
         o_pipe_reset <= 1'b0;
         o_imem_we    <= 1'b0;
         o_imem_addr  <= '0;
         o_imem_data  <= 32'd0;
         o_loaded     <= 1'b0;
         o_load_err   <= 1'b0;
         o_done       <= 1'b0;
      end else begin
         o_imem_we    <= 1'b0;
         o_pipe_reset <= 1'b0;
         o_enable     <= 1'b0;
         case (state)
            IDLE: begin
               if (i_rx_valid) begin
                  if (i_rx_data == CMD_LOAD) begin
                     state       <= LOAD;
                     o_imem_addr <= '0;
                     byte_cnt    <= 2'd0;
                     o_loaded    <= 1'b0;
                     o_load_err  <= 1'b0;
                  end else if (o_loaded && (i_rx_data == CMD_RUN)) begin
                     o_pipe_reset <= 1'b1;
                     state        <= RUN;
                  end else if (o_loaded && (i_rx_data == CMD_STEP)) begin
                     o_pipe_reset <= 1'b1;
                     state        <= STEP;
                  end
               end
            end

            LOAD: begin
               // Address advances only after a write that kept us loading, so it never wraps.
               if (o_imem_we) begin
                  o_imem_addr <= o_imem_addr + 1'b1;
               end
               if (i_rx_valid) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  case (byte_cnt)
                     2'd0: word_lo[7:0]   <= i_rx_data;
                     2'd1: word_lo[15:8]  <= i_rx_data;
                     2'd2: word_lo[23:16] <= i_rx_data;
                     default: begin
                        o_imem_we   <= 1'b1;
                        o_imem_data <= full_word;
                        if (full_word == HALT_WORD) begin
                           o_loaded <= 1'b1;
                           state    <= IDLE;
                        end else if (o_imem_addr == ADDR_MAX) begin
                           o_load_err <= 1'b1;
                           o_loaded   <= 1'b0;
                           state      <= IDLE;
                        end
                     end
                  endcase
               end
            end

            RUN: begin
               // During the pipe reset cycle the pipeline may still report the previous halt; ignore it.
               if (i_halt && !o_pipe_reset) begin
                  o_done <= 1'b1;
                  state  <= DONE;
               end else begin
                  o_enable <= 1'b1;
               end
            end

            STEP: begin
               // Halt takes priority over a step strobe arriving in the same cycle.
               if (i_halt && !o_pipe_reset) begin
                  o_done <= 1'b1;
                  state  <= DONE;
               end else if (i_rx_valid) begin
                  if (i_rx_data == CMD_STEP) begin
                     o_enable <= 1'b1;
                  end else if (i_rx_data == CMD_RUN) begin
                     o_enable <= 1'b1;
                     state    <= RUN;
                  end
               end
            end

            DONE: begin
               if (i_rx_valid) begin
                  if (i_rx_data == CMD_LOAD) begin
                     o_done      <= 1'b0;
                     state       <= LOAD;
                     o_imem_addr <= '0;
                     byte_cnt    <= 2'd0;
                     o_loaded    <= 1'b0;
                     o_load_err  <= 1'b0;
                  end else if (i_rx_data == CMD_RUN) begin
                     o_done       <= 1'b0;
                     o_pipe_reset <= 1'b1;
                     state        <= RUN;
                  end else if (i_rx_data == CMD_STEP) begin
                     o_done       <= 1'b0;
                     o_pipe_reset <= 1'b1;
                     state        <= STEP;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CYCLE_COUNT_EN
   logic [31:0] cycle_cnt;

   // Counts enabled cycles; restarts with each pipeline reset and saturates at all ones.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cycle_cnt <= 32'd0;
      end else if (o_pipe_reset) begin
         cycle_cnt <= 32'd0;
      end else if (o_enable && (cycle_cnt != 32'hFFFF_FFFF)) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

   assign o_cycle_count = cycle_cnt;
`else
   assign o_cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
module tb_pipeline_debug_ctrl;

   localparam int ADDR_W = 2;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic              clk;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              halt;
   logic              enable;
   logic              pipe_reset;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic              loaded;
   logic              load_err;
   logic              done;
   logic [31:0]       cycle_count;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];

   int total = 0;
   int bad   = 0;

   int wr_cnt, pr_cnt, en_cycles, en_rises, cur_run, max_run;
   logic prev_en;

   pipeline_debug_ctrl #(.ADDR_W(ADDR_W)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_rx_data    (rx_data),
      .i_rx_valid   (rx_valid),
      .i_halt       (halt),
      .o_enable     (enable),
      .o_pipe_reset (pipe_reset),
      .o_imem_we    (imem_we),
      .o_imem_addr  (imem_addr),
      .o_imem_data  (imem_data),
      .o_loaded     (loaded),
      .o_load_err   (load_err),
      .o_done       (done),
      .o_cycle_count(cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Output monitor: scoreboard for memory writes plus enable/pipe-reset statistics.
   always @(negedge clk) begin
      if (imem_we) begin
         wr_cnt++;
         check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(imem_addr), e.addr);
            check("wr_data", imem_data, e.data);
         end
      end
      if (pipe_reset) pr_cnt++;
      if (enable) begin
         en_cycles++;
         cur_run++;
         if (!prev_en) en_rises++;
      end else begin
         if (cur_run > max_run) max_run = cur_run;
         cur_run = 0;
      end
      prev_en = enable;
   end

   task automatic clr_mon();
      wr_cnt = 0; pr_cnt = 0; en_cycles = 0; en_rises = 0; cur_run = 0; max_run = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic send_word(input logic [31:0] w, input logic [31:0] addr);
      wr_t e;
      e.addr = addr;
      e.data = w;
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   logic [31:0] exp_cnt6, exp_cnt3;

   initial begin
`ifdef CYCLE_COUNT_EN
      exp_cnt6 = 32'd6;
      exp_cnt3 = 32'd3;
`else
      exp_cnt6 = 32'd0;
      exp_cnt3 = 32'd0;
`endif
      prev_en = 1'b0;
      clr_mon();
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; halt = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_enable", 32'(enable), 32'd0);
      check("rst_pipe_reset", 32'(pipe_reset), 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_loaded", 32'(loaded), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cycles", cycle_count, 32'd0);
      rst = 1'b0;
      settle(1);
      clr_mon();

      // Commands with no program, and an unknown byte, are ignored
      send_byte(8'h43);
      send_byte(8'h58);
      send_byte(8'h53);
      settle(4);
      check("ign_pipe_resets", 32'(pr_cnt), 32'd0);
      check("ign_enables", 32'(en_cycles), 32'd0);
      check("ign_loaded", 32'(loaded), 32'd0);
      check("ign_done", 32'(done), 32'd0);

      // Load two words; the second is the halt word
      clr_mon();
      send_byte(8'h4C);
      send_word(32'h2000_0001, 32'd0);
      send_word(HALT, 32'd1);
      settle(3);
      check("load_writes", 32'(wr_cnt), 32'd2);
      check("load_q_empty", 32'(exp_q.size()), 32'd0);
      check("load_loaded", 32'(loaded), 32'd1);
      check("load_err", 32'(load_err), 32'd0);

      // Continuous run, halt raised 5 cycles after first enable
      clr_mon();
      send_byte(8'h43);
      check("run_pr_pulse", 32'(pipe_reset), 32'd1);
      check("run_en_during_pr", 32'(enable), 32'd0);
      @(negedge clk);
      check("run_first_en", 32'(enable), 32'd1);
      repeat (5) @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      check("run_en_after_halt", 32'(enable), 32'd0);
      check("run_done", 32'(done), 32'd1);
      settle(3);
      check("run_en_cycles", 32'(en_cycles), 32'd6);
      check("run_pipe_resets", 32'(pr_cnt), 32'd1);
      check("run_cycle_count", cycle_count, exp_cnt6);
      halt = 1'b0;

      // Single step: three step strobes, each giving one enabled cycle
      clr_mon();
      send_byte(8'h53);
      check("step_pr_pulse", 32'(pipe_reset), 32'd1);
      check("step_done_clr", 32'(done), 32'd0);
      for (int k = 0; k < 3; k++) begin
         repeat (10) @(negedge clk);
         send_byte(8'h53);
         check("step_en_pulse", 32'(enable), 32'd1);
      end
      @(negedge clk);
      check("step_en_width", 32'(enable), 32'd0);
      settle(3);
      check("step_pipe_resets", 32'(pr_cnt), 32'd1);
      check("step_rises", 32'(en_rises), 32'd3);
      check("step_en_cycles", 32'(en_cycles), 32'd3);
      check("step_max_run", 32'(max_run), 32'd1);
      check("step_cycle_count", cycle_count, exp_cnt3);

      // Halt and step strobe together: halt wins
      clr_mon();
      halt = 1'b1;
      send_byte(8'h53);
      check("hs_enable", 32'(enable), 32'd0);
      check("hs_done", 32'(done), 32'd1);
      halt = 1'b0;
      settle(2);
      check("hs_en_cycles", 32'(en_cycles), 32'd0);

      // Overflow: four non-halt words fill a 4-word memory
      clr_mon();
      send_byte(8'h4C);
      check("ovf_done_clr", 32'(done), 32'd0);
      for (int a = 0; a < 4; a++) send_word(32'hA5A5_0000 | 32'(a), 32'(a));
      settle(3);
      check("ovf_writes", 32'(wr_cnt), 32'd4);
      check("ovf_q_empty", 32'(exp_q.size()), 32'd0);
      check("ovf_err", 32'(load_err), 32'd1);
      check("ovf_loaded", 32'(loaded), 32'd0);
      check("ovf_addr_nowrap", 32'(imem_addr), 32'd3);
      clr_mon();
      send_byte(8'h43);
      settle(5);
      check("ovf_run_ignored", 32'(en_cycles), 32'd0);
      check("ovf_no_pr", 32'(pr_cnt), 32'd0);

      // Reset in the middle of a load, then a fresh halt-only load
      check("pre_rst_cycles", cycle_count, exp_cnt3);
      send_byte(8'h4C);
      send_byte(8'h12);
      send_byte(8'h34);
      rst = 1'b1;
      #1;
      check("mid_rst_err", 32'(load_err), 32'd0);
      check("mid_rst_loaded", 32'(loaded), 32'd0);
      check("mid_rst_cycles", cycle_count, 32'd0);
      check("mid_rst_enable", 32'(enable), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      settle(1);
      clr_mon();
      send_byte(8'h4C);
      send_word(HALT, 32'd0);
      settle(3);
      check("reload_writes", 32'(wr_cnt), 32'd1);
      check("reload_q_empty", 32'(exp_q.size()), 32'd0);
      check("reload_loaded", 32'(loaded), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
